// File: rtl/uart_prog_loader.sv
// UART program loader: packs received bytes little-endian into 32-bit words,
// writes CELL_NUMBERS words into instruction memory and holds the core in reset
// until the image is complete.
// Optional trailer checksum: define LOADER_CHECKSUM_EN.
module uart_prog_loader #(
  parameter int unsigned CELL_NUMBERS = 64,
  parameter int unsigned ADDR_WIDTH   = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  cpu_rst_o,
  output logic                  load_done_o,
  output logic                  checksum_err_o
);

  localparam logic [ADDR_WIDTH-1:0] LastWord = ADDR_WIDTH'(CELL_NUMBERS - 1);

  typedef enum logic [1:0] {StLoad, StCheck, StRun, StError} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0]   word_cnt_q, word_cnt_d;
  logic [31:0]             shift_q, shift_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic                    load_done_q, load_done_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              sum_q, sum_d;
  logic                    err_q, err_d;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StLoad;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      shift_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_done_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      shift_q     <= shift_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      load_done_q <= load_done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  // Next-state logic: byte packing, word write strobe and load/run sequencing.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    shift_d     = shift_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_done_d = load_done_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      StLoad: begin
        if (rx_valid_i) begin
          shift_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data_i;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_cnt_q;
            mem_wdata_d = shift_d;
            word_cnt_d  = word_cnt_q + 1'b1;
            // Leave LOAD on the last strobe so a trailing byte in the write
            // cycle is never taken as image data.
            if (word_cnt_q == LastWord) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = StCheck;
`else
              state_d = StRun;
`endif
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (rx_valid_i) begin
          if (rx_data_i == sum_q) begin
            state_d     = StRun;
            load_done_d = 1'b1;
          end else begin
            state_d = StError;
            err_d   = 1'b1;
          end
        end
      end
      StError: ;
`endif
      // Without the checksum this registers done one cycle after the last write.
      StRun:   load_done_d = 1'b1;
      default: state_d = StLoad;
    endcase
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign load_done_o = load_done_q;
  assign cpu_rst_o   = ~load_done_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum_err_o = err_q;
`else
  assign checksum_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader (CELL_NUMBERS=4). Expected words,
// write cycles and status outputs are derived from the byte stream it sends.
// Honours LOADER_CHECKSUM_EN when defined.
module tb_uart_prog_loader;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       mem_we;
  logic [1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic       cpu_rst, load_done, checksum_err;

  uart_prog_loader #(.CELL_NUMBERS(N), .ADDR_WIDTH(2)) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rx_valid_i    (rx_valid),
    .rx_data_i     (rx_data),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .cpu_rst_o     (cpu_rst),
    .load_done_o   (load_done),
    .checksum_err_o(checksum_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0]  img [4*N];
  int          got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  int          exp_cyc[$];

  // Capture every memory write seen by the bench.
  always @(negedge clk) begin
    if (mem_we) begin
      got_addr.push_back(int'(mem_addr));
      got_data.push_back(mem_wdata);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // One reset cycle with a competing rx strobe, then check reset values.
  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_cksum_err", checksum_err, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_image(input int gap_max, input bit good);
    logic [7:0] sum;
    logic [31:0] w;
    bit exp_done;
    sum = 8'd0;
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    exp_cyc.delete();
    for (int i = 0; i < 4 * N; i++) begin
      idle($urandom_range(gap_max));
      if (i % 4 == 3) exp_cyc.push_back(cyc + 1);
      send_byte(img[i]);
      sum = sum + img[i];
    end
`ifdef LOADER_CHECKSUM_EN
    exp_done = good;
    idle($urandom_range(gap_max));
    send_byte(good ? sum : sum + 8'd1);
    @(negedge clk);
    chk("ck_done", load_done, exp_done);
    chk("ck_err", checksum_err, !exp_done);
    chk("ck_cpu_rst", cpu_rst, !exp_done);
    @(posedge clk);
    #1;
`else
    exp_done = 1'b1;
    if (good) ;
    @(negedge clk);
    chk("done_early", load_done, 0);
    chk("cpu_rst_early", cpu_rst, 1);
    @(negedge clk);
    chk("done", load_done, 1);
    chk("cpu_rst_run", cpu_rst, 0);
    @(posedge clk);
    #1;
`endif
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(2));
      send_byte(8'($urandom));
    end
    idle(3);
    chk("hold_done", load_done, exp_done);
    chk("hold_cpu_rst", cpu_rst, !exp_done);
    chk("nwrites", got_addr.size(), N);
    for (int i = 0; i < N && i < got_addr.size(); i++) begin
      w = {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
      chk($sformatf("addr%0d", i), got_addr[i], i);
      chk($sformatf("data%0d", i), got_data[i], w);
      chk($sformatf("lat%0d", i), got_cyc[i], exp_cyc[i]);
    end
  endtask

  task automatic fill_words(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] ws [4];
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    for (int i = 0; i < 4 * N; i++) img[i] = ws[i/4][8*(i%4) +: 8];
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4 * N; i++) img[i] = 8'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Single-word lui encoding followed by a directed image.
    fill_words(32'h0000C137, 32'h22222222, 32'h33333333, 32'h44444444);
    run_image(3, 1'b1);
    do_reset();
    fill_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    run_image(0, 1'b1);

    // Mid-load reset: partial image then a fresh back-to-back image.
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    do_reset();
    fill_random();
    run_image(0, 1'b1);

    // Randomized images with random gaps.
    for (int k = 0; k < 4; k++) begin
      do_reset();
      fill_random();
      run_image(k, 1'b1);
    end

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    fill_random();
    run_image(2, 1'b0);
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Sits between the UART byte receiver and the instruction memory inside cpu_uart_top.
- Assembles incoming UART bytes into little-endian 32-bit instruction words and writes CELL_NUMBERS words sequentially into instruction memory.
- Holds the CPU core in reset while loading; releases it once the program image is complete.

Parameters:
- CELL_NUMBERS, 64, number of 32-bit words in the program image (≥2).
- ADDR_WIDTH, 6, instruction memory word-address width; must satisfy 2**ADDR_WIDTH ≥ CELL_NUMBERS.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_valid  input  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  input  8  received UART byte.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  ADDR_WIDTH  word address for the write.
- mem_wdata  output  32  assembled instruction word.
- cpu_rst  output  1  reset to CPU core; 1 while loading.
- load_done  output  1  program image loaded and accepted.
- checksum_err  output  1  image checksum mismatch (see Optional Feature).

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, load_done=0, checksum_err=0.
- Reset also clears byte_cnt (2-bit), word_cnt, the shift register and the checksum accumulator, and enters state LOAD.
- States: LOAD, CHECK (only with the feature), RUN, ERROR (only with the feature).
- LOAD:
  - Each rx_valid=1 cycle places rx_data into byte lane byte_cnt (lane 0 = bits 7:0, lane 3 = bits 31:24), then increments byte_cnt (wraps 3→0).
  - The cycle after the 4th byte's strobe: mem_we=1 for exactly one cycle, mem_addr=word_cnt, mem_wdata=assembled word. word_cnt then increments.
  - Write latency is 1 cycle from the 4th byte strobe.
  - rx_valid during the mem_we cycle is accepted as byte 0 of the next word; no byte is dropped.
  - mem_addr and mem_wdata hold their values between pulses.
  - When the write of word CELL_NUMBERS-1 occurs, the next state is RUN, or CHECK with the feature.
- RUN:
  - cpu_rst=0 and load_done=1 from the cycle after the final mem_we pulse.
  - Remains in RUN until rst; all further rx_valid strobes are ignored.
  - mem_we stays 0 and memory is never rewritten.
- rst asserted mid-load: partial word discarded, word_cnt=0, cpu_rst=1 and load_done=0 in the next cycle.
  - The whole image must be resent from word 0.
- rx_valid with rst=1 is ignored; rst takes priority.
- Idle gaps of any length between bytes are legal; no timeout.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit accumulator sums every image byte modulo 256.
  - After the last word the block enters CHECK and waits for one extra byte.
  - Byte equal to the accumulator: go to RUN (cpu_rst=0, load_done=1 the cycle after that byte's strobe).
  - Byte not equal: go to ERROR with checksum_err=1, cpu_rst=1, load_done=0, held until rst.
  - In CHECK and ERROR, mem_we stays 0.
- Not defined:
  - No accumulator, no CHECK or ERROR state.
  - checksum_err is tied to 0.
  - LOAD goes directly to RUN.

Test Plan (CELL_NUMBERS=4 unless noted):
- Single word: bytes 37,C1,00,00 as word 0 (lui x2,0xC) → one cycle after the 4th strobe mem_we=1, mem_addr=0, mem_wdata=0x0000C137. After the full image, the core writes reg 2 with 0xC000.
- Full image: 16 bytes encoding words 0x11111111, 0x22222222, 0x33333333, 0x44444444 → exactly 4 mem_we pulses at addr 0..3 with those values. cpu_rst=0 and load_done=1 the cycle after the 4th pulse; 4 further bytes cause no mem_we.
- Back-to-back: rx_valid on consecutive cycles, including during mem_we → all 16 bytes land correctly; no lost or duplicated byte.
- Mid-load reset: 6 bytes, rst for 1 cycle, then the full 16-byte image → first write is to addr 0 with the fresh bytes; no stale lanes in any word.
- LOADER_CHECKSUM_EN, good checksum: image bytes sum to 0x5A, trailer 0x5A → load_done=1, checksum_err=0.
- LOADER_CHECKSUM_EN, bad checksum: trailer 0x5B → checksum_err=1, cpu_rst stays 1. After rst, checksum_err=0 and cpu_rst=1.
